// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush control, sticky stall-timeout flag
// and optional statistics counters (enabled by defining PIPE_STAGE_STATS_EN).
module pipe_stage_reg #(
    parameter int DATA_W        = 32,
    parameter int NUM_DATA      = 2,
    parameter int CTRL_W        = 4,
    parameter int RD_W          = 5,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    input  logic [RD_W-1:0]            rd_i,
    output logic                       valid_o,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o,
    output logic [RD_W-1:0]            rd_o,
    output logic                       stall_timeout_o,
    output logic [15:0]                stall_cnt_o,
    output logic [15:0]                bubble_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADED,
        ST_HELD
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(STALL_TIMEOUT);

    state_t              state_reg, state_next;
    logic [CTRL_W-1:0]   ctrl_reg, ctrl_next;
    logic [RD_W-1:0]     rd_reg;
    logic [15:0]         run_reg, run_next;
    logic                timeout_reg, timeout_next;
    logic                load_en;

    assign load_en = !stall_i && !flush_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (load_en && valid_i)
                    state_next = ST_LOADED;
            end
            ST_LOADED: begin
                if (flush_i || (!stall_i && !valid_i))
                    state_next = ST_EMPTY;
                else if (stall_i)
                    state_next = ST_HELD;
            end
            ST_HELD: begin
                if (flush_i || (!stall_i && !valid_i))
                    state_next = ST_EMPTY;
                else if (!stall_i)
                    state_next = ST_LOADED;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Control bits are masked by valid so an empty stage never carries live control.
    always_comb begin
        ctrl_next = ctrl_reg;
        if (flush_i)
            ctrl_next = '0;
        else if (!stall_i)
            ctrl_next = ctrl_i & {CTRL_W{valid_i}};
    end

    always_comb begin
        run_next = '0;
        if (stall_i)
            run_next = (run_reg == 16'hFFFF) ? run_reg : run_reg + 16'd1;
        timeout_next = timeout_reg || (run_next >= TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_EMPTY;
            ctrl_reg    <= '0;
            rd_reg      <= '0;
            run_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ctrl_reg    <= ctrl_next;
            run_reg     <= run_next;
            timeout_reg <= timeout_next;
            if (load_en)
                rd_reg <= rd_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DATA; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_reg;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    lane_reg <= '0;
                else if (load_en)
                    lane_reg <= data_i[gi*DATA_W +: DATA_W];
            end

            assign data_o[gi*DATA_W +: DATA_W] = lane_reg;
        end
    endgenerate

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] bubble_cnt_reg;

    // Stall cycles overridden by a flush count as bubbles only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (stall_i && !flush_i && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (flush_i && bubble_cnt_reg != 16'hFFFF)
                bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o  = stall_cnt_reg;
    assign bubble_cnt_o = bubble_cnt_reg;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

    assign valid_o         = (state_reg != ST_EMPTY);
    assign ctrl_o          = ctrl_reg;
    assign rd_o            = rd_reg;
    assign stall_timeout_o = timeout_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: pass-through, masking, stall hold, flush
// priority, stall timeout and asynchronous reset in the middle of a stall.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_i;
    logic        rst_n_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic [3:0]  ctrl_i;
    logic [63:0] data_i;
    logic [4:0]  rd_i;
    logic        valid_o;
    logic [3:0]  ctrl_o;
    logic [63:0] data_o;
    logic [4:0]  rd_o;
    logic        stall_timeout_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] bubble_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    int m_stall  = 0;
    int m_bub    = 0;
    logic [63:0] exp_data;

    pipe_stage_reg #(
        .DATA_W(32), .NUM_DATA(2), .CTRL_W(4), .RD_W(5), .STALL_TIMEOUT(4)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i),
        .valid_o(valid_o), .ctrl_o(ctrl_o), .data_o(data_o), .rd_o(rd_o),
        .stall_timeout_o(stall_timeout_o), .stall_cnt_o(stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [3:0] c,
                              input logic [63:0] d, input logic [4:0] r);
        check({tag, "_valid"}, 64'(valid_o), 64'(v));
        check({tag, "_ctrl"},  64'(ctrl_o),  64'(c));
        check({tag, "_data"},  data_o,       d);
        check({tag, "_rd"},    64'(rd_o),    64'(r));
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stall_cnt"},  64'(stall_cnt_o),  STATS ? 64'(m_stall) : 64'd0);
        check({tag, "_bubble_cnt"}, 64'(bubble_cnt_o), STATS ? 64'(m_bub)   : 64'd0);
    endtask

    task automatic step();
        if (stall_i && !flush_i) m_stall++;
        if (flush_i) m_bub++;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        ctrl_i = '0; data_i = '0; rd_i = '0;
        #2;
        check_outs("reset", 1'b0, 4'h0, 64'h0, 5'd0);
        check("reset_timeout", 64'(stall_timeout_o), 64'd0);
        check_stats("reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // pass-through
        valid_i = 1'b1; ctrl_i = 4'b1011; data_i = 64'hDEADBEEF_12345678; rd_i = 5'd7;
        step();
        check_outs("pass", 1'b1, 4'b1011, 64'hDEADBEEF_12345678, 5'd7);

        // invalid input masks control
        valid_i = 1'b0; ctrl_i = 4'b1111; data_i = 64'hAAAA5555_0F0F0F0F; rd_i = 5'd9;
        step();
        check_outs("mask", 1'b0, 4'h0, 64'hAAAA5555_0F0F0F0F, 5'd9);

        // stall hold with changing inputs; timeout trips on 4th stalled edge
        valid_i = 1'b1; ctrl_i = 4'b0101; data_i = 64'h11112222_33334444; rd_i = 5'd3;
        exp_data = data_i;
        step();
        check_outs("load", 1'b1, 4'b0101, exp_data, 5'd3);
        stall_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            valid_i = i[0]; ctrl_i = 4'(i); data_i = {$urandom, $urandom}; rd_i = 5'(i + 10);
            step();
            check($sformatf("hold%0d_rd", i), 64'(rd_o), 64'd3);
            check($sformatf("hold%0d_valid", i), 64'(valid_o), 64'd1);
            check($sformatf("hold%0d_timeout", i), 64'(stall_timeout_o), (i >= 4) ? 64'd1 : 64'd0);
        end
        check_outs("hold_end", 1'b1, 4'b0101, exp_data, 5'd3);
        check_stats("hold_end");

        stall_i = 1'b0; valid_i = 1'b1; ctrl_i = 4'b1110; data_i = 64'h55556666_77778888; rd_i = 5'd4;
        exp_data = data_i;
        step();
        check_outs("reload", 1'b1, 4'b1110, exp_data, 5'd4);
        check("sticky_timeout", 64'(stall_timeout_o), 64'd1);

        // flush wins over stall
        stall_i = 1'b1; flush_i = 1'b1; ctrl_i = 4'b1111; data_i = 64'h99990000_99990000; rd_i = 5'd12;
        step();
        check_outs("flush_prio", 1'b0, 4'h0, exp_data, 5'd4);
        check_stats("flush_prio");

        stall_i = 1'b0;
        step();
        check_outs("flush_only", 1'b0, 4'h0, exp_data, 5'd4);
        check_stats("flush_only");

        // asynchronous reset while HELD
        flush_i = 1'b0; valid_i = 1'b1; ctrl_i = 4'b0011; data_i = 64'hCAFEF00D_0BADBEEF; rd_i = 5'd6;
        step();
        stall_i = 1'b1;
        step();
        step();
        check_outs("held", 1'b1, 4'b0011, 64'hCAFEF00D_0BADBEEF, 5'd6);
        #2;
        rst_n_i = 1'b0;
        #1;
        m_stall = 0; m_bub = 0;
        check_outs("async_rst", 1'b0, 4'h0, 64'h0, 5'd0);
        check("async_rst_timeout", 64'(stall_timeout_o), 64'd0);
        check_stats("async_rst");
        rst_n_i = 1'b1;

        // first edge after reset loads normally
        stall_i = 1'b0; valid_i = 1'b1; ctrl_i = 4'b1001; data_i = 64'h01234567_89ABCDEF; rd_i = 5'd2;
        step();
        check_outs("resume", 1'b1, 4'b1001, 64'h01234567_89ABCDEF, 5'd2);

        // stall while empty counts towards timeout; a gap restarts the run
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; stall_i = 1'b1;
        repeat (3) step();
        check("empty_run3_timeout", 64'(stall_timeout_o), 64'd0);
        check("empty_run3_valid", 64'(valid_o), 64'd0);
        stall_i = 1'b0; valid_i = 1'b0;
        step();
        stall_i = 1'b1; valid_i = 1'b1;
        repeat (3) step();
        check("gap_run3_timeout", 64'(stall_timeout_o), 64'd0);
        step();
        check("empty_run4_timeout", 64'(stall_timeout_o), 64'd1);
        check_outs("empty_run4", 1'b0, 4'h0, 64'h01234567_89ABCDEF, 5'd2);
        check_stats("empty_run4");
        stall_i = 1'b0; valid_i = 1'b0;
        step();
        check("final_sticky_timeout", 64'(stall_timeout_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
